bcd_countdown_timer: RTL and testbench

//  Parametrised BCD countdown core for the countdown-timer app. It counts a loadable preset down to zero, one step per TICK enable.

---
 rtl/bcd_countdown_timer.sv | 171 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - BCD countdown core with start/pause, alarm window; optional BCD_TIMER_AUTORELOAD_EN
module bcd_countdown_timer #(
    parameter int                   DECADES     = 4,
    parameter int                   MMSS_MODE   = 1,
    parameter logic [4*DECADES-1:0] PRESET      = 16'h0100,
    parameter int                   ALARM_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   load,
    input  logic [4*DECADES-1:0]   load_val,
    output logic [4*DECADES-1:0]   q,
    output logic                   running,
    output logic                   done,
    output logic                   alarm
);

    localparam int          W          = 4 * DECADES;
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [7:0]  ALARM_INIT = 8'(ALARM_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] q_next;
    logic [7:0]   alarm_cnt, alarm_cnt_next;
    logic         running_next, done_next, hit_zero;
    logic [W-1:0] q_dec, load_clean;
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [W-1:0] reload_val, reload_next;
`endif

    // One BCD step down; digit 1 wraps to 5 in MM:SS mode so seconds stay below 60
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DECADES; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = (MMSS_MODE != 0 && i == 1) ? 4'd5 : 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Clamp each digit into its legal range so loaded values are valid BCD
    function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = v;
        for (int i = 0; i < DECADES; i++) begin
            d = v[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            if (MMSS_MODE != 0 && i == 1 && d > 4'd5) d = 4'd5;
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Registered state, count, alarm counter and decoded status outputs
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            q         <= PRESET;
            alarm_cnt <= 8'd0;
            running   <= 1'b0;
            done      <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_val <= PRESET;
`endif
        end else begin
            state     <= state_next;
            q         <= q_next;
            alarm_cnt <= alarm_cnt_next;
            running   <= running_next;
            done      <= done_next;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_val <= reload_next;
`endif
        end
    end

    // Next state: LOAD beats STOP beats START; a TICK in RUN always takes its step
    always_comb begin
        state_next     = state;
        q_next         = q;
        alarm_cnt_next = alarm_cnt;
        hit_zero       = 1'b0;
        q_dec          = bcd_dec(q);
        load_clean     = bcd_sanitise(load_val);
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_next    = reload_val;
`endif
        if (load) begin
            state_next     = S_IDLE;
            q_next         = load_clean;
            alarm_cnt_next = 8'd0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_next    = load_clean;
`endif
        end else if (stop) begin
            state_next     = S_IDLE;
            q_next         = PRESET;
            alarm_cnt_next = 8'd0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_next    = PRESET;
`endif
        end else begin
            if (start) begin
                case (state)
                    S_IDLE:  if (q != '0) state_next = S_RUN;
                    S_RUN:   state_next = S_PAUSE;
                    S_PAUSE: state_next = S_RUN;
                    S_DONE: begin
                        state_next     = S_IDLE;
                        alarm_cnt_next = 8'd0;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
            if (state == S_RUN && tick) begin
                if (q == ONE) begin
                    // Reaching zero wins over a simultaneous pause
                    hit_zero       = 1'b1;
                    alarm_cnt_next = ALARM_INIT;
`ifdef BCD_TIMER_AUTORELOAD_EN
                    q_next         = reload_val;
`else
                    q_next         = '0;
                    state_next     = S_DONE;
`endif
                end else begin
                    q_next = q_dec;
                end
            end
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (tick && !hit_zero && alarm_cnt != 8'd0)
                alarm_cnt_next = alarm_cnt - 8'd1;
`else
            if (state == S_DONE && tick && !start && alarm_cnt != 8'd0)
                alarm_cnt_next = alarm_cnt - 8'd1;
`endif
        end
        running_next = (state_next == S_RUN);
`ifdef BCD_TIMER_AUTORELOAD_EN
        done_next    = hit_zero;
`else
        done_next    = (state_next == S_DONE);
`endif
    end

    assign alarm = (alarm_cnt != 8'd0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for bcd_countdown_timer against an arithmetic reference model
module tb_bcd_countdown_timer;

    localparam int          DECADES     = 4;
    localparam int          MMSS_MODE   = 1;
    localparam logic [15:0] PRESET      = 16'h0100;
    localparam int          ALARM_TICKS = 8;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct packed {
        logic [15:0] q;
        logic        running;
        logic        done;
        logic        alarm;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] q;
    logic        running, done, alarm;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    int m_state = M_IDLE;
    int m_val   = 0;
    int m_alarm = 0;
    int m_reload = 0;
    bit m_done_pulse = 0;

    bcd_countdown_timer #(
        .DECADES(DECADES), .MMSS_MODE(MMSS_MODE), .PRESET(PRESET), .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk(clk), .clr(clr), .tick(tick), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .q(q), .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic int radix(int i);
        return (MMSS_MODE != 0 && i == 1) ? 6 : 10;
    endfunction

    // BCD (possibly mixed radix) to plain count of steps
    function automatic int to_int(logic [15:0] v);
        int r = 0, w = 1;
        for (int i = 0; i < DECADES; i++) begin
            r += int'(v[4*i +: 4]) * w;
            w *= radix(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r = '0;
        for (int i = 0; i < DECADES; i++) begin
            r[4*i +: 4] = 4'(n % radix(i));
            n = n / radix(i);
        end
        return r;
    endfunction

    function automatic int sanitised_value(logic [15:0] v);
        logic [15:0] c = v;
        for (int i = 0; i < DECADES; i++) begin
            if (c[4*i +: 4] > 4'd9) c[4*i +: 4] = 4'd9;
            if (MMSS_MODE != 0 && i == 1 && c[4*i +: 4] > 4'd5) c[4*i +: 4] = 4'd5;
        end
        return to_int(c);
    endfunction

    // Reference behaviour for one clock edge, expressed as counts of steps
    task automatic model_edge(input bit c, input bit t, input bit s, input bit p, input bit l, input logic [15:0] lv);
        int  old;
        bit  stepping;
        bit  reached;
        m_done_pulse = 0;
        if (!c) begin
            m_val = to_int(PRESET); m_state = M_IDLE; m_alarm = 0; m_reload = m_val;
        end else if (l) begin
            m_val = sanitised_value(lv); m_state = M_IDLE; m_alarm = 0; m_reload = m_val;
        end else if (p) begin
            m_val = to_int(PRESET); m_state = M_IDLE; m_alarm = 0; m_reload = m_val;
        end else begin
            old      = m_state;
            stepping = (old == M_RUN) && t;
            reached  = stepping && (m_val == 1);
            if (s) begin
                if (old == M_IDLE && m_val != 0) m_state = M_RUN;
                else if (old == M_RUN)           m_state = M_PAUSE;
                else if (old == M_PAUSE)         m_state = M_RUN;
                else if (old == M_DONE) begin m_state = M_IDLE; m_alarm = 0; end
            end
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (t && !reached && m_alarm > 0) m_alarm--;
`else
            if (old == M_DONE && t && !s && m_alarm > 0) m_alarm--;
`endif
            if (stepping) m_val = m_val - 1;
            if (reached) begin
                m_alarm = ALARM_TICKS;
`ifdef BCD_TIMER_AUTORELOAD_EN
                m_val = m_reload;
                m_done_pulse = 1;
`else
                m_state = M_DONE;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, return after the edge
    task automatic step(input bit c, input bit t, input bit s, input bit p, input bit l, input logic [15:0] lv);
        exp_t e;
        clr = c; tick = t; start = s; stop = p; load = l; load_val = lv;
        model_edge(c, t, s, p, l, lv);
        e.q       = to_bcd(m_val);
        e.running = (m_state == M_RUN);
`ifdef BCD_TIMER_AUTORELOAD_EN
        e.done    = m_done_pulse;
`else
        e.done    = (m_state == M_DONE);
`endif
        e.alarm   = (m_alarm != 0);
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_tick(); step(1, 1, 0, 0, 0, 16'h0); endtask
    task automatic do_start(); step(1, 0, 1, 0, 0, 16'h0); endtask
    task automatic do_load(input logic [15:0] v); step(1, 0, 0, 0, 1, v); endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard monitor: one expected entry per edge, compared half a cycle later
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (q !== e.q) begin
                n_errors++;
                $display("FAIL sb_q: got %h expected %h at %0t", q, e.q, $time);
            end
            n_checks++;
            if ({running, done, alarm} !== {e.running, e.done, e.alarm}) begin
                n_errors++;
                $display("FAIL sb_flags(run,done,alarm): got %b%b%b expected %b%b%b at %0t",
                         running, done, alarm, e.running, e.done, e.alarm, $time);
            end
        end
    end

    initial begin
        logic [15:0] lv;
        #2;
        step(0, 0, 0, 0, 0, 16'h0);
        chk("reset_q", q, 16'h0100);
        chk("reset_flags", {13'd0, running, done, alarm}, 16'h0);

        do_start();
        chk("start_running", {15'd0, running}, 16'h1);
        idle_tick();
        chk("mmss_borrow", q, 16'h0059);

`ifdef BCD_TIMER_AUTORELOAD_EN
        do_load(16'h0001);
        do_start();
        idle_tick();
        chk("ar_q", q, 16'h0001);
        chk("ar_run_done", {14'd0, running, done}, 16'h3);
        step(1, 0, 0, 0, 0, 16'h0);
        chk("ar_done_pulse", {15'd0, done}, 16'h0);
`else
        do_load(16'h0002);
        do_start();
        idle_tick();
        idle_tick();
        chk("zero_q", q, 16'h0000);
        chk("zero_done_alarm", {14'd0, done, alarm}, 16'h3);
        repeat (7) idle_tick();
        chk("alarm_held", {15'd0, alarm}, 16'h1);
        idle_tick();
        chk("alarm_expired", {14'd0, done, alarm}, 16'h2);
        do_start();
        chk("done_to_idle", {14'd0, running, done}, 16'h0);
`endif

        do_load(16'h0010);
        do_start();
        step(1, 1, 1, 0, 0, 16'h0);
        chk("pause_step_q", q, 16'h0009);
        chk("pause_running", {15'd0, running}, 16'h0);
        idle_tick();
        idle_tick();
        chk("pause_hold_q", q, 16'h0009);

        do_load(16'h1A7C);
        chk("sanitise", q, 16'h1959);
        do_load(16'h0000);
        do_start();
        chk("start_at_zero", {15'd0, running}, 16'h0);

        do_load(16'h0033);
        do_start();
        idle_tick();
        chk("run_q", q, 16'h0032);
        step(0, 1, 0, 0, 0, 16'h0);
        chk("midrun_reset_q", q, 16'h0100);
        chk("midrun_reset_run", {15'd0, running}, 16'h0);

        // Randomised traffic, load values biased small so zero is reached often
        for (int n = 0; n < 3000; n++) begin
            lv = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 12)) : 16'($urandom);
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 47) == 0),
                 ($urandom_range(0, 23) == 0),
                 lv);
        end
        step(1, 0, 0, 0, 0, 16'h0);

        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
